fetch_pc_stage: RTL and testbench
=================================

Name: fetch_pc_stage

Overview:
- F-stage PC register plus F/D pipeline register for the 5-stage MIPS core.
- Consumes the D-stage branch comparison result `cmp_o` and the D-stage jump decode. Selects the next PC from sequential, branch, j/jal or jr targets.
- Presents the fetch address to the instruction memory and registers the fetched instruction into D.
- Branch delay slot semantics: the instruction after a branch/jump always enters D.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset; also the reset value of d_pc.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into D on reset or annul.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; freezes PC and the F/D register.
- f_instr  in  32  instruction word read from IM at f_pc (combinational IM).
- br_en  in  1  instruction in D is a conditional branch.
- cmp_o  in  1  branch condition result for the D instruction.
- j_en  in  1  instruction in D is j/jal.
- jr_en  in  1  instruction in D is jr/jalr.
- d_rs_val  in  32  forwarded rs value in D (jr target).
- f_pc  out  32  current fetch PC to IM.
- d_pc  out  32  PC of the instruction held in D.
- d_instr  out  32  instruction held in D.
- d_valid  out  1  D holds a real instruction (0 after reset or annul).
- d_likely  in  1  only with BRANCH_LIKELY_EN; D branch is a "likely" variant.

Behaviour:
- Reset (reset=1 at posedge, overrides everything including stall): f_pc=PC_RESET, d_pc=PC_RESET, d_instr=NOP_INSTR, d_valid=0.
- Target arithmetic (modulo 2^32, carries above bit 31 discarded), using D fields d_instr[15:0] (imm16) and d_instr[25:0] (idx):
  - seq = f_pc+4
  - br = d_pc+4+({{14{imm16[15]}},imm16,2'b00})
  - j = {d_pc[31:28],idx,2'b00}
  - jr = d_rs_val, used unmodified with no alignment check.
- Next-PC select, priority order:
  1. jr_en → jr
  2. j_en → j
  3. br_en & cmp_o → br
  4. otherwise → seq
- Simultaneous enables are illegal from decode but must resolve deterministically by that priority.
- Redirect inputs are qualified by d_valid: when d_valid=0, select seq.
- Normal cycle (stall=0): f_pc ← selected next PC; d_pc ← f_pc; d_instr ← f_instr; d_valid ← 1.
  - The delay-slot instruction is the one fetched at f_pc while the branch is in D, and it is captured normally.
- Stall cycle (stall=1): f_pc, d_pc, d_instr, d_valid all hold.
  - Redirects are ignored and re-evaluated on the first non-stalled cycle with that cycle's cmp_o/d_rs_val, since forwarded operands are only valid then.
- Latency: a redirect asserted in cycle N (not stalled) appears on f_pc at cycle N+1. The delay slot enters D at N+1, and the target instruction enters D at N+2.
- f_pc wraps from 32'hFFFF_FFFC to 32'h0000_0000 without error.
- Reset asserted mid-stall or mid-redirect: reset wins; the redirect is lost.

Optional Feature:
- Macro: BRANCH_LIKELY_EN.
- Defined:
  - Port d_likely exists.
  - A non-stalled cycle with d_valid & br_en & d_likely & !cmp_o loads d_instr=NOP_INSTR and d_valid=0 (delay slot annulled); d_pc still ← f_pc.
  - f_pc still advances to seq.
- Undefined: port absent; the delay slot is always executed.

Decomposition:
- Shared package `mips_pkg`:
  - NPC select constants NPC_SEQ=2'd0, NPC_BR=2'd1, NPC_J=2'd2, NPC_JR=2'd3
  - PC_RESET default and NOP_INSTR constants
  - opcode field slice constants for imm16 and idx.
- One natural sub-module: `npc_calc`, combinational target computation and priority select. fetch_pc_stage holds only the registers, stall and annul logic.

Test Plan:
- Reset: hold reset 2 cycles → f_pc=0x3000, d_pc=0x3000, d_instr=0, d_valid=0. Release → f_pc sequence 0x3004, 0x3008; d_pc lags f_pc by one cycle.
- Taken beq: D at d_pc=0x3008, imm16=0xFFFE, br_en=1, cmp_o=1 → next f_pc=0x3004. The delay slot fetched at 0x300C is in D next cycle.
- Not-taken branch: br_en=1, cmp_o=0 at d_pc=0x3010 → f_pc=0x3018 (sequential). Delay slot valid (d_valid=1 without the macro).
- jr plus stall: jr_en=1, d_rs_val=0x0000_4000 with stall=1 for 2 cycles → all outputs held. On stall=0 → f_pc=0x4000. Also check that asserting j_en simultaneously still yields 0x4000.
- j target: d_pc=0x3020, idx=26'h0000_C10 → f_pc=0x0000_3040. Wrap case: f_pc=0xFFFF_FFFC → next 0x0.
- BRANCH_LIKELY_EN: br_en=1, d_likely=1, cmp_o=0 → next d_instr=0, d_valid=0, f_pc advances by 4. Same with cmp_o=1 → delay slot valid, f_pc=target.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end: next-PC select codes,
// reset/NOP constants, instruction field positions and branch offset helper.
package mips_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    localparam logic [31:0] PC_RESET_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    localparam int IMM16_LSB = 0;
    localparam int IMM16_MSB = 15;
    localparam int IDX_LSB   = 0;
    localparam int IDX_MSB   = 25;

    // Sign-extended word offset of a conditional branch, in bytes.
    function automatic logic [31:0] br_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_stage_npc_calc.sv
// Next-PC computation: sequential, branch, j/jal and jr targets with
// fixed priority jr > j > taken branch > sequential, gated by d_valid.
module npc_calc
    import mips_pkg::*;
(
    input  logic [31:0] f_pc,
    input  logic [31:0] d_pc,
    input  logic [25:0] d_idx,
    input  logic        d_valid,
    input  logic        br_en,
    input  logic        cmp_o,
    input  logic        j_en,
    input  logic        jr_en,
    input  logic [31:0] d_rs_val,
    output logic [31:0] npc
);

    logic [31:0] seq_target;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [15:0] imm16;
    npc_sel_e    sel;

    assign imm16      = d_idx[IMM16_MSB:IMM16_LSB];
    assign seq_target = f_pc + 32'd4;
    assign br_target  = d_pc + 32'd4 + br_offset(imm16);
    assign j_target   = {d_pc[31:28], d_idx[IDX_MSB:IDX_LSB], 2'b00};

    always_comb begin
        // NOTE: default first so every path assigns sel; no latch is inferred.
        sel = NPC_SEQ;
        if (d_valid) begin
            if (jr_en)
                sel = NPC_JR;
            else if (j_en)
                sel = NPC_J;
            else if (br_en && cmp_o)
                sel = NPC_BR;
        end
    end

    always_comb begin
        npc = seq_target;
        case (sel)
            NPC_BR:  npc = br_target;
            NPC_J:   npc = j_target;
            NPC_JR:  npc = d_rs_val;
            default: npc = seq_target;
        endcase
    end

endmodule

// File: rtl/fetch_pc_stage.sv
// F-stage PC register and F/D pipeline register with branch delay slot.
// Define BRANCH_LIKELY_EN to add d_likely and annul untaken likely delay slots.
module fetch_pc_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] f_instr,
    input  logic        br_en,
    input  logic        cmp_o,
    input  logic        j_en,
    input  logic        jr_en,
    input  logic [31:0] d_rs_val,
`ifdef BRANCH_LIKELY_EN
    input  logic        d_likely,
`endif
    output logic [31:0] f_pc,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic        d_valid
);

    logic [31:0] npc;
    logic        annul;

    npc_calc u_npc_calc (
        .f_pc     (f_pc),
        .d_pc     (d_pc),
        .d_idx    (d_instr[IDX_MSB:IDX_LSB]),
        .d_valid  (d_valid),
        .br_en    (br_en),
        .cmp_o    (cmp_o),
        .j_en     (j_en),
        .jr_en    (jr_en),
        .d_rs_val (d_rs_val),
        .npc      (npc)
    );

`ifdef BRANCH_LIKELY_EN
    // Untaken likely branch: the delay slot is squashed, fetch still goes sequential.
    assign annul = d_valid & br_en & d_likely & ~cmp_o;
`else
    assign annul = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values of the others.
        if (reset) begin
            f_pc    <= PC_RESET;
            d_pc    <= PC_RESET;
            d_instr <= NOP_INSTR;
            d_valid <= 1'b0;
        end else if (!stall) begin
            f_pc <= npc;
            d_pc <= f_pc;
            if (annul) begin
                d_instr <= NOP_INSTR;
                d_valid <= 1'b0;
            end else begin
                d_instr <= f_instr;
                d_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Scoreboard bench for fetch_pc_stage: directed walk through the fetch scenarios
// followed by randomized traffic, checked against an architectural model.
module tb_fetch_pc_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] f_instr = '0;
    logic        br_en = 1'b0;
    logic        cmp_o = 1'b0;
    logic        j_en = 1'b0;
    logic        jr_en = 1'b0;
    logic [31:0] d_rs_val = '0;
    logic        d_likely = 1'b0;
    logic [31:0] f_pc;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        d_valid;

    fetch_pc_stage dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .f_instr  (f_instr),
        .br_en    (br_en),
        .cmp_o    (cmp_o),
        .j_en     (j_en),
        .jr_en    (jr_en),
        .d_rs_val (d_rs_val),
`ifdef BRANCH_LIKELY_EN
        .d_likely (d_likely),
`endif
        .f_pc     (f_pc),
        .d_pc     (d_pc),
        .d_instr  (d_instr),
        .d_valid  (d_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] fpc;
        logic [31:0] dpc;
        logic [31:0] dinstr;
        logic        dvalid;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_cyc = 0;
    logic [31:0] imem[logic [31:0]];

    logic [31:0] m_fpc = 32'h0000_3000;
    logic [31:0] m_dpc = 32'h0000_3000;
    logic [31:0] m_dinstr = 32'h0;
    logic        m_dvalid = 1'b0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (imem.exists(a))
            return imem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, n_cyc, act, exp);
        end
    endtask

    // Issue one cycle of stimulus and record what the pipeline must hold after the edge.
    task automatic cyc(input logic rst, input logic st, input logic br, input logic cmp,
                       input logic j, input logic jr, input logic [31:0] rs, input logic lk);
        logic [31:0] nxt;
        logic        squash;
        int          off;
        @(negedge clk);
        reset = rst; stall = st; br_en = br; cmp_o = cmp; j_en = j; jr_en = jr;
        d_rs_val = rs; d_likely = lk;
        f_instr = mem_rd(m_fpc);
        if (rst) begin
            m_fpc = 32'h0000_3000; m_dpc = 32'h0000_3000;
            m_dinstr = 32'h0; m_dvalid = 1'b0;
        end else if (!st) begin
            nxt = m_fpc + 32'd4;
            if (m_dvalid) begin
                off = int'($signed(m_dinstr[15:0]));
                if (jr)
                    nxt = rs;
                else if (j)
                    nxt = {m_dpc[31:28], 28'(m_dinstr[25:0] * 4)};
                else if (br && cmp)
                    nxt = m_dpc + 32'd4 + 32'(off * 4);
            end
            squash = 1'b0;
`ifdef BRANCH_LIKELY_EN
            squash = m_dvalid && br && lk && !cmp;
`endif
            m_dpc    = m_fpc;
            m_dinstr = squash ? 32'h0 : f_instr;
            m_dvalid = !squash;
            m_fpc    = nxt;
        end
        sb.push_back('{m_fpc, m_dpc, m_dinstr, m_dvalid});
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        n_cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("f_pc", f_pc, e.fpc);
            check("d_pc", d_pc, e.dpc);
            check("d_instr", d_instr, e.dinstr);
            check("d_valid", {31'h0, d_valid}, {31'h0, e.dvalid});
        end
    end

    initial begin
        imem[32'h0000_3008] = 32'h1000_FFFE;
        imem[32'h0000_3010] = 32'h1000_0005;
        imem[32'h0000_3020] = 32'h0800_0C10;
        imem[32'h0000_0000] = 32'h5000_0010;

        // Reset held two cycles, then sequential fetch.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (3) idle();
        // Taken backward branch at 0x3008, delay slot 0x300C.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (4) idle();
        // Not-taken branch at 0x3010.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        // jr held off by stall, then released together with j_en.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4000, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4000, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_4000, 1'b0);
        // Steer to 0x3020 and take the j there.
        idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3020, 1'b0);
        idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        // Wrap from 0xFFFF_FFFC.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        idle();
        idle();
        // Likely branch at address 0, untaken then taken.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        idle();
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        idle();
        // Reset during a stalled redirect.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_8000, 1'b0);
        idle();

        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            r = $urandom;
            cyc($urandom_range(0, 99) < 2, r[1:0] == 2'b00,
                r[4:2] == 3'b000, r[5], r[8:6] == 3'b000, r[11:9] == 3'b000,
                $urandom & 32'hFFFF_FFFC, r[12]);
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++)
            @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
